// File: rtl/cache_mem_pkg.sv
// Shared types and encodings for the I/D-cache to memory arbiter.
package cache_mem_pkg;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
    localparam logic [2:0] WR_TYPE_HALF = 3'b001;
    localparam logic [2:0] WR_TYPE_WORD = 3'b010;
    localparam logic [2:0] WR_TYPE_LINE = 3'b100;

    localparam int LINE_OFS_DEFAULT = 4;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } rd_master_e;

    typedef struct packed {
        logic [2:0]   wtype;
        logic [31:0]  addr;
        logic [3:0]   wstrb;
        logic [127:0] data;
    } wr_entry_t;

    // Two addresses fall in the same cache line when everything above the line offset matches.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b, input int ofs);
        return (a >> ofs) == (b >> ofs);
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side handshake bundle; slave is the arbiter's view, master the environment's.
interface cache_mem_arbiter_if;

    logic         i_rd_req;
    logic [2:0]   i_rd_type;
    logic [31:0]  i_rd_addr;
    logic         i_rd_rdy;
    logic         i_ret_valid;
    logic         i_ret_last;
    logic [31:0]  i_ret_data;

    logic         d_rd_req;
    logic [2:0]   d_rd_type;
    logic [31:0]  d_rd_addr;
    logic         d_rd_rdy;
    logic         d_ret_valid;
    logic         d_ret_last;
    logic [31:0]  d_ret_data;

    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;

    logic         mem_rd_req;
    logic [2:0]   mem_rd_type;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_rdy;
    logic         mem_ret_valid;
    logic         mem_ret_last;
    logic [31:0]  mem_ret_data;

    logic         mem_wr_req;
    logic [2:0]   mem_wr_type;
    logic [31:0]  mem_wr_addr;
    logic [3:0]   mem_wr_wstrb;
    logic [127:0] mem_wr_data;
    logic         mem_wr_rdy;

    logic         proto_err;

    modport slave (
        input  i_rd_req, i_rd_type, i_rd_addr,
        output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        input  d_rd_req, d_rd_type, d_rd_addr,
        output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        output d_wr_rdy,
        output mem_rd_req, mem_rd_type, mem_rd_addr,
        input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
        output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        input  mem_wr_rdy,
        output proto_err
    );

    modport master (
        output i_rd_req, i_rd_type, i_rd_addr,
        input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
        output d_rd_req, d_rd_type, d_rd_addr,
        input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
        output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
        input  d_wr_rdy,
        input  mem_rd_req, mem_rd_type, mem_rd_addr,
        output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
        input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
        output mem_wr_rdy,
        input  proto_err
    );

endinterface

// File: rtl/cache_wr_buffer.sv
// One-entry D-cache write-back buffer with a same-line compare for read-after-write ordering.
module cache_wr_buffer
    import cache_mem_pkg::*;
#(
    parameter int LINE_OFS = LINE_OFS_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        push_valid,
    input  wr_entry_t   push_entry,
    output logic        push_rdy,
    output logic        pop_valid,
    output wr_entry_t   pop_entry,
    input  logic        pop_rdy,
    input  logic [31:0] cmp_addr,
    output logic        hazard
);

    logic      valid_q, valid_d;
    wr_entry_t entry_q, entry_d;

    // Push is only accepted while empty, so push and pop can never fall in the same cycle.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        valid_d  = valid_q;
        entry_d  = entry_q;
        push_rdy = !valid_q;
        if (push_valid && push_rdy) begin
            valid_d = 1'b1;
            entry_d = push_entry;
        end else if (valid_q && pop_rdy) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) valid_q <= 1'b0;
        else         valid_q <= valid_d;
    end

    // NOTE: the payload is deliberately not reset; valid_q alone qualifies it, which keeps the wide data path free of reset routing.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    assign pop_valid = valid_q;
    assign pop_entry = entry_q;
    assign hazard    = valid_q && same_line(cmp_addr, entry_q.addr, LINE_OFS);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory read channel (round-robin, burst-routed) and one write channel between I- and D-cache.
module cache_mem_arbiter
    import cache_mem_pkg::*;
#(
    parameter bit RR       = 1'b1,
    parameter int LINE_OFS = LINE_OFS_DEFAULT
) (
    input logic               clk,
    input logic               resetn,
    cache_mem_arbiter_if.slave bus
);

    rd_state_e   state_q, state_d;
    rd_master_e  owner_q, owner_d;
    rd_master_e  last_q, last_d;
    logic [2:0]  rd_type_q, rd_type_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        proto_err_q, proto_err_d;

    rd_master_e  win;
    logic [31:0] win_addr;
    logic [2:0]  win_type;
    logic        hazard;
    logic        i_rd_rdy, d_rd_rdy, mem_rd_req;
    logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    wr_entry_t   wr_push, wr_pop;

    // With both requesting, RR favours whoever was not granted last; otherwise D always wins.
    assign win      = (bus.d_rd_req && (!bus.i_rd_req || !RR || last_q == OWN_I)) ? OWN_D : OWN_I;
    assign win_addr = (win == OWN_D) ? bus.d_rd_addr : bus.i_rd_addr;
    assign win_type = (win == OWN_D) ? bus.d_rd_type : bus.i_rd_type;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rd_type_d   = rd_type_q;
        rd_addr_d   = rd_addr_q;
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        mem_rd_req  = 1'b0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        unique case (state_q)
            RD_IDLE: begin
                // A hazarded winner keeps the grant slot; the loser waits rather than slipping past.
                if (win == OWN_D) d_rd_rdy = bus.d_rd_req && !hazard;
                else              i_rd_rdy = bus.i_rd_req && !hazard;
                if (i_rd_rdy || d_rd_rdy) begin
                    owner_d   = win;
                    last_d    = win;
                    rd_type_d = win_type;
                    rd_addr_d = win_addr;
                    state_d   = RD_REQ;
                end
            end
            RD_REQ: begin
                mem_rd_req = 1'b1;
                if (bus.mem_rd_rdy) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (owner_q == OWN_D) begin
                    d_ret_valid = bus.mem_ret_valid;
                    d_ret_last  = bus.mem_ret_last;
                end else begin
                    i_ret_valid = bus.mem_ret_valid;
                    i_ret_last  = bus.mem_ret_last;
                end
                if (bus.mem_ret_valid && bus.mem_ret_last) state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
        proto_err_d = proto_err_q || (bus.mem_ret_valid && state_q != RD_RESP);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RD_IDLE;
            owner_q     <= OWN_I;
            last_q      <= OWN_I;
            rd_type_q   <= RD_TYPE_BYTE;
            rd_addr_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rd_type_q   <= rd_type_d;
            rd_addr_q   <= rd_addr_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign wr_push = '{wtype: bus.d_wr_type, addr: bus.d_wr_addr,
                       wstrb: bus.d_wr_wstrb, data: bus.d_wr_data};

    cache_wr_buffer #(.LINE_OFS(LINE_OFS)) u_wbuf (
        .clk        (clk),
        .resetn     (resetn),
        .push_valid (bus.d_wr_req),
        .push_entry (wr_push),
        .push_rdy   (bus.d_wr_rdy),
        .pop_valid  (bus.mem_wr_req),
        .pop_entry  (wr_pop),
        .pop_rdy    (bus.mem_wr_rdy),
        .cmp_addr   (win_addr),
        .hazard     (hazard)
    );

    assign bus.mem_wr_type  = wr_pop.wtype;
    assign bus.mem_wr_addr  = wr_pop.addr;
    assign bus.mem_wr_wstrb = wr_pop.wstrb;
    assign bus.mem_wr_data  = wr_pop.data;

    assign bus.i_rd_rdy     = i_rd_rdy;
    assign bus.d_rd_rdy     = d_rd_rdy;
    assign bus.i_ret_valid  = i_ret_valid;
    assign bus.i_ret_last   = i_ret_last;
    assign bus.d_ret_valid  = d_ret_valid;
    assign bus.d_ret_last   = d_ret_last;
    assign bus.i_ret_data   = bus.mem_ret_data;
    assign bus.d_ret_data   = bus.mem_ret_data;
    assign bus.mem_rd_req   = mem_rd_req;
    assign bus.mem_rd_type  = rd_type_q;
    assign bus.mem_rd_addr  = rd_addr_q;
    assign bus.proto_err    = proto_err_q;

endmodule
